// File: rtl/aes_pkg.sv
// Shared AES datapath constants and the byte-0-is-MSB slicing helper used by
// the ShiftRows, MixColumns and SubBytes stages.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_NBYTES  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } isb_state_e;

  // Byte k of the state sits at bits [byte_msb(k) -: AES_BYTE_W].
  function automatic int unsigned byte_msb(input int unsigned k);
    return AES_STATE_W - 1 - AES_BYTE_W * k;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box (FIPS-197 table), one byte in, one byte out.
module inv_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Entry 0 occupies the top byte; each row below holds 16 consecutive entries.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  logic [10:0] msb;

  assign msb   = 11'd2047 - {in_i, 3'b000};
  assign out_o = INV_SBOX_TBL[msb -: 8];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// AES InvSubBytes stage: captures one state, substitutes BYTES_PER_CYCLE bytes
// per cycle through shared inverse S-boxes, then holds the result until taken.
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_data
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid never waits for ready, and out_valid/out_data hold until taken.

  localparam int B       = BYTES_PER_CYCLE;
  localparam int NGROUPS = AES_NBYTES / B;
  localparam int CNT_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam int GRP_W   = B * AES_BYTE_W;
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NGROUPS - 1);

  if (!(B == 1 || B == 2 || B == 4 || B == 8 || B == 16)) begin : g_bad_param
    $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  isb_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [AES_STATE_W-1:0] work_q;
  logic [AES_STATE_W-1:0] work_d;
  logic [AES_STATE_W-1:0] out_data_q;
  logic                   out_valid_q;
  logic [GRP_W-1:0]       grp_in;
  logic [GRP_W-1:0]       grp_out;

  // Group selection falls back to group 0 so the S-boxes never see X.
  always_comb begin
    grp_in = work_q[byte_msb(0) -: GRP_W];
    work_d = work_q;
    for (int g = 0; g < NGROUPS; g++) begin
      if (cnt_q == CNT_W'(g)) begin
        grp_in = work_q[byte_msb(g * B) -: GRP_W];
        work_d[byte_msb(g * B) -: GRP_W] = grp_out;
      end
    end
  end

  for (genvar i = 0; i < B; i++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .in_i  (grp_in[GRP_W-1-i*AES_BYTE_W -: AES_BYTE_W]),
      .out_o (grp_out[GRP_W-1-i*AES_BYTE_W -: AES_BYTE_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            work_q  <= in_data;
            cnt_q   <= '0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          work_q <= work_d;
          if (cnt_q == LAST_GRP) begin
            state_q     <= ST_DONE;
            cnt_q       <= '0;
            out_data_q  <= work_d;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              work_q  <= in_data;
              cnt_q   <= '0;
              state_q <= ST_BUSY;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq plus a randomised sweep across all
// legal BYTES_PER_CYCLE values against an independently derived model.
module tb_inv_sub_bytes_seq;

  localparam logic [127:0] C1_IN  = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
  localparam logic [127:0] C1_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  logic         sw_in_valid;
  logic [127:0] sw_in_data;
  logic         sw_out_ready;
  logic         sw_in_ready  [5];
  logic         sw_out_valid [5];
  logic [127:0] sw_out_data  [5];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] ref_inv [256];

  // ---------------- clock / reset / DUTs ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_sub_bytes_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  for (genvar g = 0; g < 5; g++) begin : g_sw
    inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (sw_in_valid),
      .in_ready  (sw_in_ready[g]),
      .in_data   (sw_in_data),
      .out_valid (sw_out_valid[g]),
      .out_ready (sw_out_ready),
      .out_data  (sw_out_data[g])
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = aa << 1;
      if (hi) aa = aa ^ 8'h1b;
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Forward S-box from GF(2^8) inverse + affine map, then inverted into a table.
  task automatic build_ref();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      ref_inv[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_inv_sub(input logic [127:0] d);
    logic [127:0] r = '0;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = ref_inv[d[127-8*k -: 8]];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic send(input logic [127:0] d, output int lat);
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(lat);
  endtask

  task automatic take();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 128'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    rst = 1'b0;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_fips();
    int lat;
    send(C1_IN, lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL fips_latency: got %0d want 4", lat); end
    n_cmp++; if (out_data !== C1_OUT) begin n_err++; $display("FAIL fips_data: got %h want %h", out_data, C1_OUT); end
    settle();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fips_in_ready_done: got %b want 0", in_ready); end
    take();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fips_after_take: got %b want 0", out_valid); end
  endtask

  task automatic test_patterns();
    logic [127:0] pin  [3];
    logic [127:0] pexp [3];
    int lat;
    pin[0] = {16{8'h63}}; pexp[0] = {16{8'h00}};
    pin[1] = {16{8'h00}}; pexp[1] = {16{8'h52}};
    pin[2] = {16{8'h16}}; pexp[2] = {16{8'hff}};
    for (int i = 0; i < 3; i++) begin
      send(pin[i], lat);
      n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL pattern%0d_latency: got %0d want 4", i, lat); end
      n_cmp++; if (out_data !== pexp[i]) begin n_err++; $display("FAIL pattern%0d_data: got %h want %h", i, out_data, pexp[i]); end
      take();
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] bexp = {8{16'h00ff}};
    int lat;
    int extra = 0;
    send({8{16'h6316}}, lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL bp_latency: got %0d want 4", lat); end
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      settle();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== bexp) begin n_err++; $display("FAIL bp_hold_data[%0d]: got %h want %h", i, out_data, bexp); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    settle();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    step();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL bp_extra_outputs: got %0d want 0", extra); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] blk  [3];
    logic [127:0] bexp [3];
    int t [3];
    int lat;
    blk[0] = {16{8'h00}}; bexp[0] = {16{8'h52}};
    blk[1] = {16{8'h63}}; bexp[1] = {16{8'h00}};
    blk[2] = C1_IN;       bexp[2] = C1_OUT;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = blk[0];
    step();
    for (int i = 0; i < 3; i++) begin
      in_valid = (i < 2);
      in_data  = (i < 2) ? blk[i+1] : 128'h0;
      wait_out(lat);
      t[i] = cyc;
      settle();
      n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL b2b_latency[%0d]: got %0d want 4", i, lat); end
      n_cmp++; if (out_data !== bexp[i]) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, out_data, bexp[i]); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
      if (i > 0) begin
        n_cmp++; if (t[i] - t[i-1] !== 5) begin n_err++; $display("FAIL b2b_period[%0d]: got %0d want 5", i, t[i] - t[i-1]); end
      end
      step();
    end
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen = 0;
    in_data  = {16{8'h63}};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 128'h0) begin n_err++; $display("FAIL rstmid_out_data: got %h want 0", out_data); end
    settle();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rstmid_ghost_output: got %0d want 0", seen); end
    send({16{8'h16}}, lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL rstmid_next_latency: got %0d want 4", lat); end
    n_cmp++; if (out_data !== {16{8'hff}}) begin n_err++; $display("FAIL rstmid_next_data: got %h want %h", out_data, {16{8'hff}}); end
    take();
  endtask

  task automatic test_sweep();
    logic [127:0] d;
    logic [127:0] e;
    int lat [5];
    for (int v = 0; v < 1000; v++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      e = ref_inv_sub(d);
      sw_in_data  = d;
      sw_in_valid = 1'b1;
      settle();
      for (int g = 0; g < 5; g++) begin
        n_cmp++; if (sw_in_ready[g] !== 1'b1) begin n_err++; $display("FAIL sweep_in_ready B=%0d vec %0d: got %b want 1", 1 << g, v, sw_in_ready[g]); end
        lat[g] = -1;
      end
      step();
      sw_in_valid = 1'b0;
      for (int c = 1; c <= 16; c++) begin
        step();
        for (int g = 0; g < 5; g++)
          if (sw_out_valid[g] && lat[g] < 0) lat[g] = c;
      end
      for (int g = 0; g < 5; g++) begin
        n_cmp++; if (lat[g] !== (16 >> g)) begin n_err++; $display("FAIL sweep_latency B=%0d vec %0d: got %0d want %0d", 1 << g, v, lat[g], 16 >> g); end
        n_cmp++; if (sw_out_data[g] !== e) begin n_err++; $display("FAIL sweep_data B=%0d vec %0d: got %h want %h", 1 << g, v, sw_out_data[g], e); end
      end
      sw_out_ready = 1'b1;
      step();
      sw_out_ready = 1'b0;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;
    sw_in_valid  = 1'b0;
    sw_in_data   = '0;
    sw_out_ready = 1'b0;
    build_ref();
    test_reset();
    test_fips();
    test_patterns();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
